// File: rtl/drivetrain_pkg.sv
// Shared drive-train definitions: quadrature phases, step codes, board clock defaults.
// Contents: Q00..Q10 phase constants, step_t encoding, WINDOW_CYC_100MHZ,
//           quad_decode() helper mapping a previous/current phase pair to a step.
package drivetrain_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  // 1 ms speed window at the 100 MHz board clock.
  localparam int WINDOW_CYC_100MHZ = 100000;

  // x4 decode of phase order {A,B}: 00 -> 01 -> 11 -> 10 -> 00 is forward.
  function automatic step_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = STEP_NONE;
    if ((prev ^ cur) == 2'b11) begin
      s = STEP_ERR;
    end else if (prev != cur) begin
      case (prev)
        Q00:     s = (cur == Q01) ? STEP_FWD : STEP_REV;
        Q01:     s = (cur == Q11) ? STEP_FWD : STEP_REV;
        Q11:     s = (cur == Q10) ? STEP_FWD : STEP_REV;
        default: s = (cur == Q00) ? STEP_FWD : STEP_REV;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/motor_encoder_reader_if.sv
// Bundle between one encoder reader and the motor-control top level.
// Inputs to the reader: enc_a/enc_b pins, clear, drive_en.
// Outputs from the reader: pos, speed, speed_valid, dir, stalled, err.
interface motor_encoder_reader_if #(
  parameter int POS_W = 16,
  parameter int SPD_W = 12
);
  logic                    enc_a;
  logic                    enc_b;
  logic                    clear;
  logic                    drive_en;
  logic signed [POS_W-1:0] pos;
  logic signed [SPD_W-1:0] speed;
  logic                    speed_valid;
  logic                    dir;
  logic                    stalled;
  logic                    err;

  // master = the encoder reader itself, slave = its consumer.
  modport master (
    input  enc_a, enc_b, clear, drive_en,
    output pos, speed, speed_valid, dir, stalled, err
  );
  modport slave (
    output enc_a, enc_b, clear, drive_en,
    input  pos, speed, speed_valid, dir, stalled, err
  );
endinterface

// File: rtl/enc_input_filter.sv
// One encoder channel: 2-flop synchronizer followed by a glitch filter.
// Ports: clk, rst_n (sync, active-low), pin_i (async pin), filt_o (filtered level).
// A change is accepted after FILT_LEN consecutive synchronized samples differ from filt_o.
module enc_input_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic filt_o
);
  localparam int CNT_W = 4;

  logic             sync1_q;
  logic             sync2_q;
  logic             filt_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      // Any sample matching the current level restarts the run count,
      // so a pulse shorter than FILT_LEN never reaches filt_q.
      if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign filt_o = filt_q;
endmodule

// File: rtl/motor_encoder_reader.sv
// Quadrature encoder reader for one track motor: position, windowed speed, direction, stall, error.
// Ports: clk, rst_n (sync, active-low), bus (motor_encoder_reader_if.master).
// Pin-to-pos latency FILT_LEN+3 cycles; speed_valid pulses every WINDOW_CYC cycles; all outputs registered.
module motor_encoder_reader
  import drivetrain_pkg::*;
#(
  parameter int FILT_LEN   = 4,
  parameter int WINDOW_CYC = WINDOW_CYC_100MHZ,
  parameter int POS_W      = 16,
  parameter int SPD_W      = 12,
  parameter int STALL_WIN  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  motor_encoder_reader_if.master bus
);
  localparam int WIN_W = $clog2(WINDOW_CYC);
  localparam int STL_W = $clog2(STALL_WIN + 1);
  localparam logic signed [SPD_W:0] SPD_MAX = $signed({2'b00, {(SPD_W-1){1'b1}}});
  localparam logic signed [SPD_W:0] SPD_MIN = -SPD_MAX;

  logic                    filt_a;
  logic                    filt_b;
  logic [1:0]              cur_ab;
  logic [1:0]              prev_q;
  step_t                   step;
  logic signed [SPD_W:0]   step_ext;
  logic signed [SPD_W:0]   acc_sum;
  logic signed [SPD_W:0]   acc_clip;
  logic                    tc;

  logic signed [POS_W-1:0] pos_q,   pos_d;
  logic signed [SPD_W-1:0] acc_q,   acc_d;
  logic signed [SPD_W-1:0] speed_q, speed_d;
  logic [WIN_W-1:0]        win_q,   win_d;
  logic [STL_W-1:0]        stall_q, stall_d;
  logic                    vld_q,   vld_d;
  logic                    dir_q,   dir_d;
  logic                    err_q,   err_d;

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .rst_n(rst_n), .pin_i(bus.enc_a), .filt_o(filt_a)
  );
  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .rst_n(rst_n), .pin_i(bus.enc_b), .filt_o(filt_b)
  );

  assign cur_ab = {filt_a, filt_b};
  assign step   = quad_decode(prev_q, cur_ab);
  assign tc     = (win_q == WIN_W'(WINDOW_CYC - 1));

  always_comb begin
    step_ext = '0;
    case (step)
      STEP_FWD: step_ext = (SPD_W+1)'(1);
      STEP_REV: step_ext = -(SPD_W+1)'(1);
      default:  step_ext = '0;
    endcase
    // One extra bit of headroom; a +-1 step can overshoot the limit by one at most.
    acc_sum  = $signed({acc_q[SPD_W-1], acc_q}) + step_ext;
    acc_clip = (acc_sum > SPD_MAX) ? SPD_MAX :
               (acc_sum < SPD_MIN) ? SPD_MIN : acc_sum;
  end

  always_comb begin
    pos_d   = pos_q;
    acc_d   = acc_q;
    speed_d = speed_q;
    win_d   = win_q;
    stall_d = stall_q;
    vld_d   = 1'b0;
    dir_d   = dir_q;
    err_d   = err_q;
    if (bus.clear) begin
      // Clear overrides a same-cycle step and terminal count; speed keeps its last value.
      pos_d   = '0;
      acc_d   = '0;
      win_d   = '0;
      stall_d = '0;
      err_d   = 1'b0;
    end else begin
      case (step)
        STEP_FWD: begin pos_d = pos_q + POS_W'(1); dir_d = 1'b1; end
        STEP_REV: begin pos_d = pos_q - POS_W'(1); dir_d = 1'b0; end
        STEP_ERR: err_d = 1'b1;
        default:  ;
      endcase
      if (tc) begin
        speed_d = acc_clip[SPD_W-1:0];
        vld_d   = 1'b1;
        acc_d   = '0;
        win_d   = '0;
        if (bus.drive_en && (acc_clip == '0)) begin
          stall_d = (stall_q == STL_W'(STALL_WIN)) ? stall_q : stall_q + STL_W'(1);
        end else begin
          stall_d = '0;
        end
      end else begin
        acc_d = acc_clip[SPD_W-1:0];
        win_d = win_q + WIN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= Q00;
      pos_q   <= '0;
      acc_q   <= '0;
      speed_q <= '0;
      win_q   <= '0;
      stall_q <= '0;
      vld_q   <= 1'b0;
      dir_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      // prev_q tracks the filtered phase even through clear, so clear never fakes a step.
      prev_q  <= cur_ab;
      pos_q   <= pos_d;
      acc_q   <= acc_d;
      speed_q <= speed_d;
      win_q   <= win_d;
      stall_q <= stall_d;
      vld_q   <= vld_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign bus.pos         = pos_q;
  assign bus.speed       = speed_q;
  assign bus.speed_valid = vld_q;
  assign bus.dir         = dir_q;
  assign bus.err         = err_q;
  assign bus.stalled     = (stall_q == STL_W'(STALL_WIN));
endmodule

// File: tb/tb_motor_encoder_reader.sv
// Bench for motor_encoder_reader: directed scenarios plus random encoder traffic.
// Reference model schedules each pin change as a step landing FILT_LEN+3 cycles later
// and tracks position, windowed speed, stall and error arithmetically.
module tb_motor_encoder_reader;
  localparam int FILT_LEN  = 4;
  localparam int WIN       = 1000;
  localparam int POS_W     = 8;
  localparam int POS4_W    = 4;
  localparam int SPD_W     = 6;
  localparam int STALL_WIN = 3;
  localparam int LAT       = FILT_LEN + 3;
  localparam int SPD_MAX   = (1 << (SPD_W - 1)) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  motor_encoder_reader_if #(.POS_W(POS_W),  .SPD_W(SPD_W)) ifc ();
  motor_encoder_reader_if #(.POS_W(POS4_W), .SPD_W(SPD_W)) ifc4 ();

  assign ifc4.enc_a    = ifc.enc_a;
  assign ifc4.enc_b    = ifc.enc_b;
  assign ifc4.clear    = ifc.clear;
  assign ifc4.drive_en = ifc.drive_en;

  motor_encoder_reader #(.FILT_LEN(FILT_LEN), .WINDOW_CYC(WIN), .POS_W(POS_W),
                         .SPD_W(SPD_W), .STALL_WIN(STALL_WIN))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  motor_encoder_reader #(.FILT_LEN(FILT_LEN), .WINDOW_CYC(WIN), .POS_W(POS4_W),
                         .SPD_W(SPD_W), .STALL_WIN(STALL_WIN))
    u_dut4 (.clk(clk), .rst_n(rst_n), .bus(ifc4));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wrap(input int v, input int w);
    int m;
    int r;
    m = 1 << w;
    r = ((v % m) + m) % m;
    return (r >= m / 2) ? r - m : r;
  endfunction

  function automatic int clip(input int v);
    return (v > SPD_MAX) ? SPD_MAX : (v < -SPD_MAX) ? -SPD_MAX : v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { int due; int kind; } ev_t;   // kind: +1, -1, or 2 for illegal
  ev_t evq[$];
  int  cyc = 0;
  int  m_pos, m_acc, m_speed, m_vld, m_dir, m_err, m_stall, m_wcnt;
  bit  chk_en = 1'b0;
  int  vld_cnt = 0;

  always @(posedge clk) begin : model
    ev_t x;
    int  d;
    bit  e;
    int  nacc;
    cyc++;
    d = 0;
    e = 1'b0;
    while (evq.size() > 0 && evq[0].due <= cyc) begin
      x = evq.pop_front();
      if (x.kind == 2) e = 1'b1;
      else d += x.kind;
    end
    if (!rst_n) begin
      m_pos = 0; m_acc = 0; m_speed = 0; m_vld = 0; m_dir = 1;
      m_err = 0; m_stall = 0; m_wcnt = 0;
      evq.delete();
    end else if (ifc.clear) begin
      m_pos = 0; m_acc = 0; m_wcnt = 0; m_stall = 0; m_err = 0; m_vld = 0;
    end else begin
      if (e) m_err = 1;
      else if (d != 0) begin
        m_pos += d;
        m_dir = (d > 0) ? 1 : 0;
      end
      nacc = clip(m_acc + d);
      if (m_wcnt == WIN - 1) begin
        m_speed = nacc;
        m_vld   = 1;
        m_acc   = 0;
        m_wcnt  = 0;
        if (ifc.drive_en && nacc == 0) m_stall = (m_stall < STALL_WIN) ? m_stall + 1 : STALL_WIN;
        else m_stall = 0;
      end else begin
        m_vld = 0;
        m_acc = nacc;
        m_wcnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (ifc.speed_valid === 1'b1) vld_cnt++;
    if (chk_en) begin
      check_val("pos",         $signed(ifc.pos),   wrap(m_pos, POS_W));
      check_val("pos4",        $signed(ifc4.pos),  wrap(m_pos, POS4_W));
      check_val("speed",       $signed(ifc.speed), m_speed);
      check_val("speed_valid", ifc.speed_valid,    m_vld);
      check_val("dir",         ifc.dir,            m_dir);
      check_val("err",         ifc.err,            m_err);
      check_val("stalled",     ifc.stalled,        (m_stall == STALL_WIN) ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [1:0] ph_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int ph_idx = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_phase();
    {ifc.enc_a, ifc.enc_b} = ph_tab[ph_idx];
  endtask

  task automatic step(input bit fwd, input int hold);
    ph_idx = (ph_idx + (fwd ? 1 : 3)) % 4;
    drive_phase();
    evq.push_back('{due: cyc + LAT, kind: (fwd ? 1 : -1)});
    tick(hold);
  endtask

  task automatic err_flip(input int hold);
    ph_idx = (ph_idx + 2) % 4;
    drive_phase();
    evq.push_back('{due: cyc + LAT, kind: 2});
    tick(hold);
  endtask

  task automatic glitch(input bit ch_a, input int len);
    if (ch_a) ifc.enc_a = ~ifc.enc_a;
    else      ifc.enc_b = ~ifc.enc_b;
    tick(len);
    drive_phase();
    tick(FILT_LEN);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    ifc.clear = 1'b0;
    ph_idx = 0;
    drive_phase();
    tick(n);
    rst_n = 1'b1;
  endtask

  // Returns one cycle after the next speed_valid pulse (aligned #1 after posedge).
  task automatic wait_vld(input int budget, input string tag);
    int n;
    n = 0;
    @(posedge clk);
    @(negedge clk);
    while (ifc.speed_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, ifc.speed_valid, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int p_exp;
    int c0;
    int r;
    ifc.enc_a = 1'b0; ifc.enc_b = 1'b0; ifc.clear = 1'b0; ifc.drive_en = 1'b0;
    rst_n = 1'b0;
    tick(1);
    chk_en = 1'b1;
    // Reset with pins toggling.
    for (int i = 0; i < 3; i++) begin
      ifc.enc_a = 1'($urandom);
      ifc.enc_b = 1'($urandom);
      tick(1);
    end
    ph_idx = 0;
    drive_phase();
    tick(1);
    check_val("rst_pos",     $signed(ifc.pos),   0);
    check_val("rst_speed",   $signed(ifc.speed), 0);
    check_val("rst_vld",     ifc.speed_valid,    0);
    check_val("rst_dir",     ifc.dir,            1);
    check_val("rst_stalled", ifc.stalled,        0);
    check_val("rst_err",     ifc.err,            0);
    rst_n = 1'b1;
    tick(LAT + 2);
    check_val("post_rst_pos", $signed(ifc.pos), 0);

    // Forward 12 cycles then reverse 12 cycles, 40 clk per phase.
    for (int i = 0; i < 48; i++) step(1'b1, 40);
    tick(LAT + 1);
    check_val("fwd_pos", $signed(ifc.pos), 48);
    check_val("fwd_dir", ifc.dir, 1);
    check_val("fwd_err", ifc.err, 0);
    for (int i = 0; i < 48; i++) step(1'b0, 40);
    tick(LAT + 1);
    check_val("rev_pos", $signed(ifc.pos), 0);
    check_val("rev_dir", ifc.dir, 0);

    // Glitch rejection then exact latency of an accepted edge.
    glitch(1'b1, FILT_LEN - 1);
    tick(LAT);
    check_val("glitch_pos", $signed(ifc.pos), 0);
    step(1'b1, 0);
    tick(LAT - 1);
    check_val("lat_before", $signed(ifc.pos), 0);
    tick(1);
    check_val("lat_at", $signed(ifc.pos), 1);
    tick(FILT_LEN);

    // Speed: 25 steps in a window, then 40 steps (saturates at 31).
    wait_vld(WIN + 10, "sync_timeout");
    c0 = vld_cnt;
    for (int i = 0; i < 25; i++) step(1'b1, 20);
    wait_vld(WIN + 10, "spd25_timeout");
    check_val("spd25", $signed(ifc.speed), 25);
    check_val("spd25_pulses", vld_cnt - c0, 1);
    for (int i = 0; i < 40; i++) step(1'b1, 20);
    wait_vld(WIN + 10, "spd40_timeout");
    check_val("spd40_sat", $signed(ifc.speed), 31);

    // Position wrap on the 4-bit instance.
    ifc.clear = 1'b1;
    tick(1);
    ifc.clear = 1'b0;
    for (int i = 0; i < 17; i++) step(1'b1, 8);
    tick(LAT + 1);
    check_val("wrap_pos4", $signed(ifc4.pos), 1);
    check_val("wrap_pos",  $signed(ifc.pos),  17);

    // Illegal 00 -> 11 transition.
    while (ph_idx != 0) step(1'b1, 8);
    tick(LAT + 1);
    p_exp = wrap(m_pos, POS_W);
    err_flip(8);
    tick(LAT + 1);
    check_val("err_set", ifc.err, 1);
    check_val("err_pos", $signed(ifc.pos), p_exp);

    // Clear on the terminal-count cycle.
    wait_vld(WIN + 10, "clr_sync_timeout");
    tick(WIN - 2);
    ifc.clear = 1'b1;
    ifc.drive_en = 1'b1;
    tick(1);
    ifc.clear = 1'b0;
    check_val("clr_vld", ifc.speed_valid, 0);
    check_val("clr_pos", $signed(ifc.pos), 0);
    check_val("clr_err", ifc.err, 0);
    tick(WIN - 1);
    check_val("clr_next_early", ifc.speed_valid, 0);
    tick(1);
    check_val("clr_next_pulse", ifc.speed_valid, 1);
    check_val("stall_after1", ifc.stalled, 0);

    // Stall detection.
    wait_vld(WIN + 10, "stall2_timeout");
    check_val("stall_after2", ifc.stalled, 0);
    wait_vld(WIN + 10, "stall3_timeout");
    check_val("stall_after3", ifc.stalled, 1);
    step(1'b1, FILT_LEN);
    wait_vld(WIN + 10, "stall_step_timeout");
    check_val("stall_cleared", ifc.stalled, 0);
    ifc.drive_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_vld(WIN + 10, "nodrive_timeout");
      check_val("nodrive_stalled", ifc.stalled, 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      step(1'b1, $urandom_range(FILT_LEN, FILT_LEN + 6));
      else if (r < 80) step(1'b0, $urandom_range(FILT_LEN, FILT_LEN + 6));
      else if (r < 88) glitch(1'($urandom), $urandom_range(1, FILT_LEN - 1));
      else if (r < 91) err_flip($urandom_range(FILT_LEN, FILT_LEN + 6));
      else if (r < 95) begin
        ifc.clear = 1'b1;
        tick(1);
        ifc.clear = 1'b0;
      end else if (r < 97) begin
        ifc.drive_en = ~ifc.drive_en;
        tick(1);
      end else if (r < 98) begin
        do_reset(3);
      end else begin
        tick($urandom_range(1, 50));
      end
    end
    tick(LAT + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
